// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES MixColumns widths, FSM state type and GF(2^8) xtime.
// Revision    : 1.0
// ============================================================================
package aes_pkg;

    localparam int C_STATE_W = 128;
    localparam int C_COL_W   = 32;
    localparam int C_BYTE_W  = 8;
    localparam logic [C_BYTE_W-1:0] C_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Multiply by x (0x02) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [C_BYTE_W-1:0] xtime(input logic [C_BYTE_W-1:0] b);
        return {b[C_BYTE_W-2:0], 1'b0} ^ (b[C_BYTE_W-1] ? C_POLY : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gf_mix_column.sv
`default_nettype none
// ============================================================================
// Module      : gf_mix_column
// Description : Combinational MixColumns / InvMixColumns of one 32-bit column.
// Revision    : 1.0
// ============================================================================
module gf_mix_column
    import aes_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [C_COL_W-1:0] col_in,
    input  logic               inv,
    output logic [C_COL_W-1:0] col_out
);

    logic [C_BYTE_W-1:0] w_a  [4];
    logic [C_BYTE_W-1:0] w_x2 [4];
    logic [C_BYTE_W-1:0] w_x4 [4];
    logic [C_BYTE_W-1:0] w_x8 [4];
    logic [C_BYTE_W-1:0] w_fwd[4];
    logic [C_BYTE_W-1:0] w_inv[4];

    generate
        for (genvar i = 0; i < 4; i++) begin : g_byte
            assign w_a[i]  = col_in[C_COL_W-1-C_BYTE_W*i -: C_BYTE_W];
            assign w_x2[i] = xtime(w_a[i]);
            assign w_x4[i] = xtime(w_x2[i]);
            assign w_x8[i] = xtime(w_x4[i]);
        end
    endgenerate

    // Row r is the base row rotated right by r: byte (r+k)%4 gets coefficient k
    generate
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int K1 = (r + 1) % 4;
            localparam int K2 = (r + 2) % 4;
            localparam int K3 = (r + 3) % 4;
            assign w_fwd[r] = w_x2[r] ^ (w_x2[K1] ^ w_a[K1]) ^ w_a[K2] ^ w_a[K3];
            assign w_inv[r] = (w_x8[r]  ^ w_x4[r]  ^ w_x2[r])
                            ^ (w_x8[K1] ^ w_x2[K1] ^ w_a[K1])
                            ^ (w_x8[K2] ^ w_x4[K2] ^ w_a[K2])
                            ^ (w_x8[K3] ^ w_a[K3]);
            assign col_out[C_COL_W-1-C_BYTE_W*r -: C_BYTE_W] =
                (INV_EN && inv) ? w_inv[r] : w_fwd[r];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mix_columns_engine.sv
`default_nettype none
// ============================================================================
// Module      : mix_columns_engine
// Description : Iterative AES (Inv)MixColumns over a 128-bit state, valid/ready.
// Revision    : 1.0
// ============================================================================
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_EN         = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [C_STATE_W-1:0] state_in,
    input  logic                 inv,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [C_STATE_W-1:0] state_out,
    output logic                 busy
);

    localparam logic [1:0] C_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] C_LAST = 2'(4 - COLS_PER_CYCLE);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    state_t                   r_state;
    logic [1:0]               r_cnt;
    logic [3:0][C_COL_W-1:0]  r_work;   // [3] is column 0 (top of state)
    logic [C_STATE_W-1:0]     r_out;
    logic                     r_inv;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_busy;

    logic [1:0]               w_idx    [COLS_PER_CYCLE];
    logic [C_COL_W-1:0]       w_col_in [COLS_PER_CYCLE];
    logic [C_COL_W-1:0]       w_col_out[COLS_PER_CYCLE];
    logic [3:0][C_COL_W-1:0]  w_next;

    generate
        for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
            assign w_idx[k]    = r_cnt + 2'(k);
            assign w_col_in[k] = r_work[2'd3 - w_idx[k]];
            gf_mix_column #(
                .INV_EN (INV_EN)
            ) u_col (
                .col_in  (w_col_in[k]),
                .inv     (r_inv),
                .col_out (w_col_out[k])
            );
        end
    endgenerate

    always_comb begin
        w_next = r_work;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            w_next[2'd3 - w_idx[k]] = w_col_out[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 2'd0;
            r_work      <= '0;
            r_out       <= '0;
            r_inv       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_work     <= state_in;
                        r_inv      <= INV_EN ? inv : 1'b0;
                        r_cnt      <= 2'd0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt + C_STEP;
                    if (r_cnt == C_LAST) begin
                        r_state     <= DONE;
                        r_out       <= w_next;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign state_out = r_out;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mix_columns_engine
// Description : Self-checking bench; four engines (1/2/4 cols, forward-only) share stimulus.
// Revision    : 1.0
// ============================================================================
module tb_mix_columns_engine;

    localparam int ND = 4;
    localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] INV_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    localparam logic [127:0] ONES    = {4{32'h01010101}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         inv = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] state_in = '0;
    logic         in_ready [ND];
    logic         out_valid[ND];
    logic         busy     [ND];
    logic [127:0] state_out[ND];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit thr   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < ND; g++) begin : g_dut
            mix_columns_engine #(
                .COLS_PER_CYCLE (g == 1 ? 2 : (g == 2 ? 4 : 1)),
                .INV_EN         (g == 3 ? 1'b0 : 1'b1)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .in_ready  (in_ready[g]),
                .state_in  (state_in),
                .inv       (inv),
                .out_valid (out_valid[g]),
                .out_ready (out_ready),
                .state_out (state_out[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    function automatic int n_of(input int d);
        return (d == 1) ? 2 : ((d == 2) ? 1 : 4);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_state(input logic [127:0] s, input bit do_inv);
        logic [7:0] fb [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
        logic [7:0] ib [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [127:0] r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                logic [7:0] acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    logic [7:0] coef = do_inv ? ib[(k - row + 4) % 4] : fb[(k - row + 4) % 4];
                    acc = acc ^ gmul(coef, s[127 - 32*c - 8*k -: 8]);
                end
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Cycle-level model: phase 0 idle, 1 computing, 2 holding a result
    int           m_phase [ND] = '{default: 0};
    int           m_left  [ND] = '{default: 0};
    int           acc_cyc [ND] = '{default: 0};
    int           hand_cnt[ND] = '{default: 0};
    logic [127:0] m_res   [ND] = '{default: '0};
    logic [127:0] m_out   [ND] = '{default: '0};

    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                m_phase[d] = 0;
                m_out[d]   = '0;
            end
            check($sformatf("dut%0d in_ready", d),  128'(in_ready[d]),  128'(m_phase[d] == 0));
            check($sformatf("dut%0d busy", d),      128'(busy[d]),      128'(m_phase[d] != 0));
            check($sformatf("dut%0d out_valid", d), 128'(out_valid[d]), 128'(m_phase[d] == 2));
            check($sformatf("dut%0d state_out", d), state_out[d],       m_out[d]);
            if (!rst) begin
                case (m_phase[d])
                    0: if (in_valid) begin
                        m_res[d]   = mix_state(state_in, inv && (d != 3));
                        m_left[d]  = n_of(d);
                        m_phase[d] = 1;
                        acc_cyc[d] = cyc;
                    end
                    1: if (m_left[d] == 1) begin
                        m_phase[d] = 2;
                        m_out[d]   = m_res[d];
                    end else begin
                        m_left[d]--;
                    end
                    default: if (out_ready) begin
                        m_phase[d] = 0;
                        if (thr) begin
                            check($sformatf("dut%0d accept-to-handoff", d),
                                  128'(cyc - acc_cyc[d]), 128'(n_of(d) + 1));
                            hand_cnt[d]++;
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_all_valid(input string tag);
        int n = 0;
        while (!(out_valid[0] && out_valid[1] && out_valid[2] && out_valid[3]) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL %s timeout: out_valid not all high after %0d cycles, want all high", tag, n);
        end
    endtask

    initial begin
        int lat[ND];

        check("model fwd vector", mix_state(FWD_IN, 1'b0), FWD_OUT);
        check("model inv vector", mix_state(INV_IN, 1'b1), INV_OUT);
        check("model ones",       mix_state(ONES, 1'b0),   ONES);

        tick();
        tick();
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset dut%0d in_ready", d),  128'(in_ready[d]),  128'(1));
            check($sformatf("reset dut%0d out_valid", d), 128'(out_valid[d]), 128'(0));
            check($sformatf("reset dut%0d state_out", d), state_out[d],       128'(0));
        end

        // Forward vector, accepted on the first edge after reset release
        out_ready = 1'b0;
        state_in  = FWD_IN;
        inv       = 1'b0;
        in_valid  = 1'b1;
        rst       = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int d = 0; d < ND; d++) lat[d] = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            for (int d = 0; d < ND; d++) if (out_valid[d] && lat[d] == 0) lat[d] = i;
        end
        for (int d = 0; d < ND; d++) begin
            check($sformatf("fwd dut%0d latency", d), 128'(lat[d]), 128'(n_of(d)));
            check($sformatf("fwd dut%0d result", d),  state_out[d], FWD_OUT);
        end
        out_ready = 1'b1;
        tick();

        // Inverse vector with 10 cycles of backpressure
        out_ready = 1'b0;
        state_in  = INV_IN;
        inv       = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        inv      = 1'b0;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        wait_all_valid("inv");
        repeat (10) tick();
        for (int d = 0; d < ND; d++) begin
            check($sformatf("bp dut%0d in_ready", d),  128'(in_ready[d]),  128'(0));
            check($sformatf("bp dut%0d out_valid", d), 128'(out_valid[d]), 128'(1));
            check($sformatf("inv dut%0d result", d), state_out[d], (d == 3) ? mix_state(INV_IN, 1'b0) : INV_OUT);
        end
        out_ready = 1'b1;
        tick();
        for (int d = 0; d < ND; d++)
            check($sformatf("release dut%0d in_ready", d), 128'(in_ready[d]), 128'(1));

        // Inputs churn after accept; result must follow the accepted values
        out_ready = 1'b0;
        state_in  = {4{32'hdb135345}};
        inv       = 1'b0;
        in_valid  = 1'b1;
        tick();
        repeat (6) begin
            inv      = ~inv;
            state_in = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        wait_all_valid("churn");
        for (int d = 0; d < ND; d++)
            check($sformatf("churn dut%0d result", d), state_out[d], {4{32'h8e4da1bc}});
        out_ready = 1'b1;
        tick();

        // Reset during the second computing cycle of the single-column engine
        out_ready = 1'b0;
        state_in  = FWD_IN;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("abort dut%0d out_valid", d), 128'(out_valid[d]), 128'(0));
            check($sformatf("abort dut%0d in_ready", d),  128'(in_ready[d]),  128'(1));
            check($sformatf("abort dut%0d state_out", d), state_out[d],       128'(0));
        end
        tick();
        rst      = 1'b0;
        state_in = ONES;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_all_valid("after abort");
        for (int d = 0; d < ND; d++)
            check($sformatf("after abort dut%0d result", d), state_out[d], ONES);
        out_ready = 1'b1;
        tick();

        // Streaming with both handshakes held high
        thr       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (520) begin
            state_in = {$urandom, $urandom, $urandom, $urandom};
            inv      = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        repeat (8) tick();
        thr = 1'b0;
        for (int d = 0; d < ND; d++)
            check($sformatf("stream dut%0d enough results", d),
                  128'(hand_cnt[d] >= 520 / (n_of(d) + 2) - 1), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
